txpu: RTL

- Transmit packet unit for the USB device endpoint; the transmit-side counterpart of the receive packet unit.
- Accepts one-cycle send_data / send_nak requests and emits complete packets as a byte stream to the NRZI/bit-stuff encoder over a valid/ready handshake.
- A data packet carries SYNC, DATA0/DATA1 PID, payload pulled from the data FIFO, CRC16 and EOP. A handshake packet carries SYNC, NAK PID and EOP.
- Drives is_tx_active so the receive path drains its FIFO while the device is talking.

---
 rtl/txpu.sv | 175 +++++++++++++++++
 1 files changed

// File: rtl/txpu.sv
// USB device transmit packet unit: serialises SYNC/PID/payload/CRC16/EOP
// or SYNC/NAK/EOP packets onto a valid/ready byte stream for the encoder.
module txpu #(
   parameter int         MAX_PAYLOAD = 8,
   parameter logic [7:0] SYNC_BYTE   = 8'h80
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       send_data,
   input  logic       send_nak,
   input  logic       ack_rcvd,
   input  logic [7:0] data_fifo_rdata,
   input  logic       data_fifo_empty,
   output logic       data_fifo_read,
   output logic [7:0] tx_byte,
   output logic       tx_valid,
   output logic       tx_eop,
   input  logic       tx_ready,
   output logic       is_tx_active
);

   localparam int            CW      = $clog2(MAX_PAYLOAD + 1);
   localparam logic [CW-1:0] MAX_CNT = CW'(MAX_PAYLOAD);
   localparam logic [7:0]    PID_NAK = 8'h5A;
   localparam logic [7:0]    PID_D0  = 8'hC3;
   localparam logic [7:0]    PID_D1  = 8'h4B;

   typedef enum logic [2:0] {
      S_IDLE, S_SYNC, S_PID, S_PAYLOAD, S_CRC_LO, S_CRC_HI, S_EOP
   } state_t;

   state_t          r_state;
   logic            r_is_nak;
   logic            r_toggle;
   logic [7:0]      r_pid;
   logic [15:0]     r_crc;
   logic [CW-1:0]   r_cnt;

   logic            w_xfer;
   logic            w_pay_done;
   logic [15:0]     w_crc_tx;

   // Reflected USB CRC16 (poly 8005 -> A001), one byte folded LSb first.
   function automatic logic [15:0] crc16_fold(input logic [15:0] crc, input logic [7:0] data);
      logic [15:0] c;
      c = crc;
      for (int i = 0; i < 8; i++) begin
         if (c[0] ^ data[i]) begin
            c = (c >> 1) ^ 16'hA001;
         end else begin
            c = c >> 1;
         end
      end
      return c;
   endfunction

   assign w_pay_done   = data_fifo_empty | (r_cnt == MAX_CNT);
   assign w_crc_tx     = ~r_crc;
   assign w_xfer       = tx_valid & tx_ready;
   assign is_tx_active = (r_state != S_IDLE);

   // Outputs are decoded from state only; tx_ready never feeds tx_valid.
   always_comb begin
      tx_byte        = 8'h00;
      tx_valid       = 1'b0;
      tx_eop         = 1'b0;
      data_fifo_read = 1'b0;
      case (r_state)
         S_SYNC: begin
            tx_byte  = SYNC_BYTE;
            tx_valid = 1'b1;
         end
         S_PID: begin
            tx_byte  = r_pid;
            tx_valid = 1'b1;
         end
         S_PAYLOAD: begin
            if (!w_pay_done) begin
               tx_byte        = data_fifo_rdata;
               tx_valid       = 1'b1;
               data_fifo_read = tx_ready;
            end else begin
               tx_byte  = 8'h00;
               tx_valid = 1'b0;
            end
         end
         S_CRC_LO: begin
            tx_byte  = w_crc_tx[7:0];
            tx_valid = 1'b1;
         end
         S_CRC_HI: begin
            tx_byte  = w_crc_tx[15:8];
            tx_valid = 1'b1;
         end
         S_EOP: begin
            tx_eop = 1'b1;
         end
         default: begin
            tx_byte = 8'h00;
         end
      endcase
   end

   // Packet sequencer, data toggle, payload counter and running CRC.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state  <= S_IDLE;
         r_is_nak <= 1'b0;
         r_toggle <= 1'b0;
         r_pid    <= 8'h00;
         r_crc    <= 16'hFFFF;
         r_cnt    <= '0;
      end else begin
         if (ack_rcvd) begin
            r_toggle <= ~r_toggle;
         end
         case (r_state)
            S_IDLE: begin
               if (send_nak) begin
                  r_is_nak <= 1'b1;
                  r_state  <= S_SYNC;
               end else if (send_data) begin
                  r_is_nak <= 1'b0;
                  r_state  <= S_SYNC;
               end
            end
            S_SYNC: begin
               // PID latched here so a later ACK only affects the next packet.
               if (w_xfer) begin
                  r_pid   <= r_is_nak ? PID_NAK : (r_toggle ? PID_D1 : PID_D0);
                  r_state <= S_PID;
               end
            end
            S_PID: begin
               if (w_xfer) begin
                  if (r_is_nak) begin
                     r_state <= S_EOP;
                  end else begin
                     r_crc   <= 16'hFFFF;
                     r_cnt   <= '0;
                     r_state <= S_PAYLOAD;
                  end
               end
            end
            S_PAYLOAD: begin
               if (w_pay_done) begin
                  r_state <= S_CRC_LO;
               end else if (w_xfer) begin
                  r_cnt <= r_cnt + CW'(1);
                  r_crc <= crc16_fold(r_crc, data_fifo_rdata);
               end
            end
            S_CRC_LO: begin
               if (w_xfer) begin
                  r_state <= S_CRC_HI;
               end
            end
            S_CRC_HI: begin
               if (w_xfer) begin
                  r_state <= S_EOP;
               end
            end
            S_EOP: begin
               if (tx_ready) begin
                  r_state <= S_IDLE;
               end
            end
            default: begin
               r_state <= S_IDLE;
            end
         endcase
      end
   end

endmodule
